mul_div_seq: RTL and testbench

- Sequential, parametrised unsigned multiply / divide / modulus unit.
- Processes one bit per clock and shares a single W-bit shift/add-subtract datapath across all operations.
- Replaces the fully unrolled single-edge multiply and divide blocks with a handshaked unit that holds its result, for use behind the arithmetic dispatch logic.
- Adds a modulus-only mode, a divide-by-zero flag and abort-on-reset.

---
 rtl/mdm_pkg.sv | 20 ++
 rtl/mdm_step.sv | 40 ++++
 rtl/mul_div_seq.sv | 127 ++++++++++++
 tb/tb_mul_div_seq.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mdm_pkg.sv
// Shared encodings for the sequential multiply / divide / modulus unit.
package mdm_pkg;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;
    localparam logic [1:0] OP_MOD = 2'b10;
    // 2'b11 is reserved and executes exactly like OP_MUL.

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // True for the operations that use the restoring-division datapath.
    function automatic logic is_divide(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/mdm_step.sv
// One iteration of the shared datapath: shift-add for multiply,
// compare-subtract-shift for restoring division.
module mdm_step #(
    parameter int W = 20
) (
    input  logic         div_i,   // 1: division step, 0: multiply step
    input  logic [W:0]   hi_i,    // accumulator high half / partial remainder
    input  logic [W-1:0] lo_i,    // accumulator low half / dividend-quotient
    input  logic [W-1:0] b_i,     // multiplier-addend or divisor
    output logic [W:0]   hi_o,
    output logic [W-1:0] lo_o
);

    logic [W:0] sum;      // acc_hi + b with carry out
    logic [W:0] shifted;  // remainder after bringing down the next dividend bit
    logic [W:0] diff;
    logic       ge;

    // Compute both candidate steps and select by mode.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (here up front), otherwise synthesis infers a latch.
        hi_o    = '0;
        lo_o    = '0;
        sum     = hi_i + (lo_i[0] ? {1'b0, b_i} : '0);
        shifted = {hi_i[W-1:0], lo_i[W-1]};
        ge      = (shifted >= {1'b0, b_i});
        diff    = shifted - {1'b0, b_i};
        if (div_i) begin
            // Restored remainder is always < b, so hi_o[W] ends up 0.
            hi_o = ge ? diff : shifted;
            lo_o = {lo_i[W-2:0], ge};
        end else begin
            // Shift {carry, acc_hi, acc_lo} right by one.
            hi_o = {1'b0, sum[W:1]};
            lo_o = {sum[0], lo_i[W-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_seq.sv
// Sequential unsigned multiply / divide / modulus, one bit per clock,
// handshaked with go/rdy and a one-cycle done pulse. Results are held.
module mul_div_seq
    import mdm_pkg::*;
#(
    parameter int W  = 20,
    parameter int CW = $clog2(W)   // derived; do not override
) (
    input  logic         t,      // clock
    input  logic         c,      // synchronous active-high reset
    input  logic         go,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         rdy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         dz
);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic [W-1:0]  b_q, b_d;
    // acc_hi is one bit wider so the division compare sees the bit shifted out.
    logic [W:0]    acc_hi_q, acc_hi_d;
    logic [W-1:0]  acc_lo_q, acc_lo_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic          dz_q, dz_d;

    logic [W:0]    step_hi;
    logic [W-1:0]  step_lo;
    logic          div_mode;

    assign div_mode = is_divide(op_q);

    mdm_step #(.W(W)) u_step (
        .div_i (div_mode),
        .hi_i  (acc_hi_q),
        .lo_i  (acc_lo_q),
        .b_i   (b_q),
        .hi_o  (step_hi),
        .lo_o  (step_lo)
    );

    assign rdy  = (state_q != S_RUN);
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign dz   = dz_q;

    // Next-state logic: accept, iterate, and capture results on the last step.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        b_d      = b_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = dz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    op_d     = op;
                    b_d      = b;
                    acc_hi_d = '0;
                    acc_lo_d = a;
                    cnt_d    = CW'(W - 1);
                    state_d  = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    dz_d    = div_mode && (b_q == '0);
                    if (op_q == OP_MOD) begin
                        hi_d = '0;
                        lo_d = step_hi[W-1:0];
                    end else begin
                        // mul: product halves; div: remainder / quotient.
                        hi_d = step_hi[W-1:0];
                        lo_d = step_lo;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything and aborts a run.
    always_ff @(posedge t) begin
        // NOTE: registers are written with <= so every flop samples the values
        // from before this edge, independent of statement order.
        if (c) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            b_q      <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            b_q      <= b_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dz_q     <= dz_d;
        end
    end

endmodule

// File: tb/tb_mul_div_seq.sv
// Directed bench for mul_div_seq at W=20 and W=8.
module tb_mul_div_seq;

    logic        t = 1'b0;
    logic        c;
    logic        go20, go8;
    logic [1:0]  op20, op8;
    logic [19:0] a20, b20;
    logic [7:0]  a8, b8;
    logic        rdy20, done20, dz20, rdy8, done8, dz8;
    logic [19:0] hi20, lo20;
    logic [7:0]  hi8, lo8;

    int n_vec = 0;
    int n_err = 0;

    always #5 t = ~t;

    mul_div_seq #(.W(20)) dut20 (
        .t(t), .c(c), .go(go20), .op(op20), .a(a20), .b(b20),
        .rdy(rdy20), .done(done20), .hi(hi20), .lo(lo20), .dz(dz20)
    );

    mul_div_seq #(.W(8)) dut8 (
        .t(t), .c(c), .go(go8), .op(op8), .a(a8), .b(b8),
        .rdy(rdy8), .done(done8), .hi(hi8), .lo(lo8), .dz(dz8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge t);
        #1;
    endtask

    // Issue one operation, scramble the inputs after accept, then check
    // latency, results and that done lasts exactly one cycle.
    task automatic run_op(input bit w8, input logic [1:0] op_v,
                          input logic [19:0] a_v, input logic [19:0] b_v,
                          input logic [19:0] hi_e, input logic [19:0] lo_e,
                          input logic dz_e, input string tag);
        int n;
        n = 0;
        while (!(w8 ? rdy8 : rdy20) && n < 100) begin tick(); n++; end
        check({tag, " rdy"}, w8 ? rdy8 : rdy20, 1);
        if (w8) begin op8 = op_v; a8 = a_v[7:0]; b8 = b_v[7:0]; go8 = 1'b1; end
        else    begin op20 = op_v; a20 = a_v; b20 = b_v; go20 = 1'b1; end
        tick();
        go8 = 1'b0; go20 = 1'b0;
        a8 = ~a8; b8 = 8'h5A; op8 = ~op8;
        a20 = ~a20; b20 = 20'h5A5A5; op20 = ~op20;
        check({tag, " busy"}, w8 ? rdy8 : rdy20, 0);
        n = 0;
        while (!(w8 ? done8 : done20) && n < 100) begin tick(); n++; end
        check({tag, " latency"}, n, w8 ? 8 : 20);
        check({tag, " hi"}, w8 ? 20'(hi8) : hi20, hi_e);
        check({tag, " lo"}, w8 ? 20'(lo8) : lo20, lo_e);
        check({tag, " dz"}, w8 ? dz8 : dz20, dz_e);
        tick();
        check({tag, " done width"}, w8 ? done8 : done20, 0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [19:0] a, b, hi, lo;
        logic        dz;
    } vec_t;

    vec_t chain [4];

    initial begin
        int n;
        c = 1'b1; go20 = 1'b0; go8 = 1'b0;
        op20 = '0; a20 = '0; b20 = '0; op8 = '0; a8 = '0; b8 = '0;
        tick(); tick();
        check("reset rdy",  rdy20,  1);
        check("reset done", done20, 0);
        check("reset hi",   hi20,   0);
        check("reset lo",   lo20,   0);
        check("reset dz",   dz20,   0);
        c = 1'b0;
        tick();

        run_op(0, 2'b00, 20'd517,   20'd141, 20'd0,  20'h11CC1, 0, "mul 517*141");
        run_op(0, 2'b01, 20'd72897, 20'd139, 20'd61, 20'd524,   0, "div 72897/139");
        run_op(0, 2'b10, 20'd72897, 20'd139, 20'd0,  20'd61,    0, "mod 72897%139");
        run_op(0, 2'b01, 20'd100,   20'd0,   20'd100, 20'hFFFFF, 1, "div by 0");
        run_op(0, 2'b10, 20'd100,   20'd0,   20'd0,  20'd100,   1, "mod by 0");
        run_op(0, 2'b00, 20'd3,     20'd4,   20'd0,  20'd12,    0, "mul 3*4");
        run_op(0, 2'b00, 20'hFFFFF, 20'hFFFFF, 20'hFFFFE, 20'h00001, 0, "mul max");
        run_op(0, 2'b11, 20'd6,     20'd7,   20'd0,  20'd42,    0, "op11 6*7");
        run_op(1, 2'b00, 20'd255,   20'd255, 20'hFE, 20'h01,    0, "w8 255*255");
        run_op(1, 2'b01, 20'd200,   20'd7,   20'd4,  20'd28,    0, "w8 200/7");

        // Abort a multiply with reset in its 5th RUN cycle.
        op20 = 2'b00; a20 = 20'd517; b20 = 20'd141; go20 = 1'b1;
        tick();
        go20 = 1'b0;
        repeat (4) tick();
        c = 1'b1;
        tick();
        c = 1'b0;
        check("abort rdy",  rdy20,  1);
        check("abort done", done20, 0);
        check("abort hi",   hi20,   0);
        check("abort lo",   lo20,   0);
        check("abort dz",   dz20,   0);
        // The fresh op's latency check also catches a stray done from the aborted one.
        run_op(0, 2'b01, 20'd200, 20'd7, 20'd4, 20'd28, 0, "after abort");

        // go held high: ignored while running, accepted in each done cycle.
        chain[0] = '{2'b00, 20'd517,   20'd141, 20'd0,   20'd72897, 1'b0};
        chain[1] = '{2'b01, 20'd72897, 20'd139, 20'd61,  20'd524,   1'b0};
        chain[2] = '{2'b10, 20'd72897, 20'd139, 20'd0,   20'd61,    1'b0};
        chain[3] = '{2'b01, 20'd100,   20'd0,   20'd100, 20'hFFFFF, 1'b1};
        op20 = chain[0].op; a20 = chain[0].a; b20 = chain[0].b; go20 = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("chain%0d busy", i), rdy20, 0);
            n = 0;
            while (!done20 && n < 100) begin
                if (n == 5) begin
                    a20 = 20'($urandom); b20 = 20'($urandom); op20 = ~op20;
                end
                tick();
                n++;
            end
            check($sformatf("chain%0d latency", i), n, 20);
            check($sformatf("chain%0d rdy in done", i), rdy20, 1);
            check($sformatf("chain%0d hi", i), hi20, chain[i].hi);
            check($sformatf("chain%0d lo", i), lo20, chain[i].lo);
            check($sformatf("chain%0d dz", i), dz20, chain[i].dz);
            if (i < 3) begin
                op20 = chain[i+1].op; a20 = chain[i+1].a; b20 = chain[i+1].b;
            end else begin
                go20 = 1'b0;
            end
            tick();
        end
        check("chain end rdy",  rdy20,  1);
        check("chain end done", done20, 0);
        check("chain hold lo",  lo20,   20'hFFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
